convolution_coprocessor_mac_sequencer: RTL and testbench

//  Sequences 1-D discrete convolution z[n] = sum_k x[k]*y[n-k] of two operand memories.

---
 rtl/convolution_coprocessor_pkg.sv | 25 ++
 rtl/convolution_coprocessor_mac_unit.sv | 39 +++
 rtl/convolution_coprocessor_mac_sequencer.sv | 165 ++++++++++++++++
 tb/tb_convolution_coprocessor_mac_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/convolution_coprocessor_pkg.sv
// Shared types and helpers for the convolution coprocessor MAC sequencer.
package convolution_coprocessor_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        FETCH = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic int acc_width(input int data_width, input int addr_width);
        return 2 * data_width + addr_width + 1;
    endfunction

    function automatic int idx_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int idx_min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/convolution_coprocessor_mac_unit.sv
// Unsigned multiplier plus accumulator; acc_next exposes the value the next edge will store.
module convolution_coprocessor_mac_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 22
) (
    input  logic                  clk,
    input  logic                  rsth,
    input  logic                  clrh,
    input  logic                  enh,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc_next
);

    logic [2*DATA_WIDTH-1:0] prod_s;
    logic [ACC_WIDTH-1:0]    acc_r;

    // product and candidate accumulator value
    always_comb begin
        prod_s = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
        if (enh) begin
            acc_next = acc_r + ACC_WIDTH'(prod_s);
        end else begin
            acc_next = acc_r;
        end
    end

    // accumulator register, clear has priority over accumulate
    always_ff @(posedge clk or posedge rsth) begin
        if (rsth) begin
            acc_r <= '0;
        end else if (clrh) begin
            acc_r <= '0;
        end else begin
            acc_r <= acc_next;
        end
    end

endmodule

// File: rtl/convolution_coprocessor_mac_sequencer.sv
// 1-D convolution sequencer: address generation, MAC control and result strobes.
// Define CONV_COPROC_SAT_EN to saturate results wider than OUT_WIDTH instead of truncating.
module convolution_coprocessor_mac_sequencer
    import convolution_coprocessor_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rsth,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   size_x_i,
    input  logic [ADDR_WIDTH:0]   size_y_i,
    output logic [ADDR_WIDTH-1:0] mem_x_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_x_data_i,
    output logic [ADDR_WIDTH-1:0] mem_y_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_y_data_i,
    output logic [ADDR_WIDTH:0]   res_addr_o,
    output logic [OUT_WIDTH-1:0]  res_data_o,
    output logic                  res_enh_o,
    output logic                  res_clrh_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, ADDR_WIDTH);
    localparam int IW        = ADDR_WIDTH + 1;
    localparam int LW        = ADDR_WIDTH + 2;
    localparam logic [IW-1:0]        SIZE_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ACC_WIDTH-1:0] OUT_MAX  = ACC_WIDTH'({OUT_WIDTH{1'b1}});

    state_t                 state;
    logic [IW-1:0]          nx_r;
    logic [IW-1:0]          ny_r;
    logic [IW-1:0]          n_r;
    logic [IW-1:0]          k_r;
    logic [IW-1:0]          kmax_r;
    logic [LW-1:0]          n_last_r;
    logic                   valid_r;

    logic [IW-1:0]          size_x_s;
    logic [IW-1:0]          size_y_s;
    logic [IW-1:0]          kmin_s;
    logic [IW-1:0]          kmax_s;
    logic                   clrh_s;
    logic [ACC_WIDTH-1:0]   acc_next_s;
    logic [OUT_WIDTH-1:0]   res_s;

    // size clamping, k window bounds and result formatting
    always_comb begin
        size_x_s = (size_x_i > SIZE_MAX) ? SIZE_MAX : size_x_i;
        size_y_s = (size_y_i > SIZE_MAX) ? SIZE_MAX : size_y_i;
        kmin_s   = IW'(idx_max(0, int'(n_r) + 1 - int'(ny_r)));
        kmax_s   = IW'(idx_min(int'(n_r), int'(nx_r) - 1));
        clrh_s   = (state == SETUP);
`ifdef CONV_COPROC_SAT_EN
        if (acc_next_s > OUT_MAX) begin
            res_s = {OUT_WIDTH{1'b1}};
        end else begin
            res_s = OUT_WIDTH'(acc_next_s);
        end
`else
        res_s = OUT_WIDTH'(acc_next_s);
`endif
    end

    convolution_coprocessor_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .rsth     (rsth),
        .clrh     (clrh_s),
        .enh      (valid_r),
        .a        (mem_x_data_i),
        .b        (mem_y_data_i),
        .acc_next (acc_next_s)
    );

    // sequencing FSM with counters and registered outputs
    always_ff @(posedge clk or posedge rsth) begin
        if (rsth) begin
            state        <= IDLE;
            nx_r         <= '0;
            ny_r         <= '0;
            n_r          <= '0;
            k_r          <= '0;
            kmax_r       <= '0;
            n_last_r     <= '0;
            valid_r      <= 1'b0;
            mem_x_addr_o <= '0;
            mem_y_addr_o <= '0;
            res_addr_o   <= '0;
            res_data_o   <= '0;
            res_enh_o    <= 1'b0;
            res_clrh_o   <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            res_enh_o  <= 1'b0;
            res_clrh_o <= 1'b0;
            done_o     <= 1'b0;
            // read data returns one cycle after each FETCH address
            valid_r    <= (state == FETCH);
            case (state)
                IDLE: begin
                    if (start_i) begin
                        nx_r     <= size_x_s;
                        ny_r     <= size_y_s;
                        n_r      <= '0;
                        n_last_r <= LW'(size_x_s) + LW'(size_y_s) - LW'(2);
                        if ((size_x_s == '0) || (size_y_s == '0)) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state      <= SETUP;
                            busy_o     <= 1'b1;
                            res_clrh_o <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    k_r          <= kmin_s;
                    kmax_r       <= kmax_s;
                    mem_x_addr_o <= ADDR_WIDTH'(kmin_s);
                    mem_y_addr_o <= ADDR_WIDTH'(n_r - kmin_s);
                    state        <= FETCH;
                end
                FETCH: begin
                    if (k_r == kmax_r) begin
                        state <= DRAIN;
                    end else begin
                        k_r          <= k_r + IW'(1);
                        mem_x_addr_o <= ADDR_WIDTH'(k_r + IW'(1));
                        mem_y_addr_o <= ADDR_WIDTH'(n_r - k_r - IW'(1));
                    end
                end
                DRAIN: begin
                    res_enh_o  <= 1'b1;
                    res_addr_o <= n_r;
                    res_data_o <= res_s;
                    state      <= WRITE;
                end
                WRITE: begin
                    n_r <= n_r + IW'(1);
                    if (LW'(n_r) == n_last_r) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        state <= SETUP;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_convolution_coprocessor_mac_sequencer.sv
// Directed self-checking bench for the convolution MAC sequencer.
module tb_convolution_coprocessor_mac_sequencer;

    logic        clk;
    logic        rsth;
    logic        start;
    logic [5:0]  size_x;
    logic [5:0]  size_y;
    logic [4:0]  x_addr;
    logic [4:0]  y_addr;
    logic [7:0]  x_data;
    logic [7:0]  y_data;
    logic [5:0]  res_addr;
    logic [15:0] res_data;
    logic        res_en;
    logic        res_clr;
    logic        busy;
    logic        done;

    logic [7:0]  xmem [32];
    logic [7:0]  ymem [32];

    int n_vec;
    int n_err;
    int wq_addr[$];
    int wq_data[$];
    int wq_cyc[$];
    int xa_q[$];
    int ya_q[$];

    localparam int EXP_Z1[4] = '{1, 3, 5, 3};
    localparam int EXP_C1[4] = '{4, 9, 14, 18};

    convolution_coprocessor_mac_sequencer dut (
        .clk          (clk),
        .rsth         (rsth),
        .start_i      (start),
        .size_x_i     (size_x),
        .size_y_i     (size_y),
        .mem_x_addr_o (x_addr),
        .mem_x_data_i (x_data),
        .mem_y_addr_o (y_addr),
        .mem_y_data_i (y_data),
        .res_addr_o   (res_addr),
        .res_data_o   (res_data),
        .res_enh_o    (res_en),
        .res_clrh_o   (res_clr),
        .busy_o       (busy),
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous-read operand memories
    always @(posedge clk) begin
        x_data <= xmem[x_addr];
        y_data <= ymem[y_addr];
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_vec({tag, "_busy"},  32'(busy),     32'd0);
        check_vec({tag, "_done"},  32'(done),     32'd0);
        check_vec({tag, "_en"},    32'(res_en),   32'd0);
        check_vec({tag, "_clr"},   32'(res_clr),  32'd0);
        check_vec({tag, "_raddr"}, 32'(res_addr), 32'd0);
        check_vec({tag, "_rdata"}, 32'(res_data), 32'd0);
        check_vec({tag, "_xaddr"}, 32'(x_addr),   32'd0);
        check_vec({tag, "_yaddr"}, 32'(y_addr),   32'd0);
    endtask

    // mode 0: plain job, 1: re-pulse start and change sizes mid-job, 2: reset in FETCH of n=2
    task automatic run_job(input int nx, input int ny, input int mode,
                           output int done_cyc, output int busy_cnt,
                           output int clr_cnt, output int clr_cyc);
        done_cyc = 0;
        busy_cnt = 0;
        clr_cnt  = 0;
        clr_cyc  = 0;
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        xa_q.delete();
        ya_q.delete();
        @(negedge clk);
        size_x = 6'(nx);
        size_y = 6'(ny);
        start  = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (mode == 1 && cyc == 5) begin
                start  = 1'b1;
                size_x = 6'd1;
                size_y = 6'd5;
            end
            if (mode == 1 && cyc == 9) start = 1'b0;
            xa_q.push_back(int'(x_addr));
            ya_q.push_back(int'(y_addr));
            if (busy) busy_cnt++;
            if (res_clr) begin
                clr_cnt++;
                clr_cyc = cyc;
            end
            if (res_en) begin
                wq_addr.push_back(int'(res_addr));
                wq_data.push_back(int'(res_data));
                wq_cyc.push_back(cyc);
            end
            if (mode == 2 && cyc == 11) begin
                rsth = 1'b1;
                #1;
                check_zero("rst_mid");
                break;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (mode != 2 && done_cyc == 0) check_vec("timeout", 32'd0, 32'd1);
    endtask

    task automatic check_basic(input string tag, input int done_cyc, input int busy_cnt,
                               input int clr_cnt, input int clr_cyc);
        check_vec({tag, "_done_cyc"}, 32'(done_cyc), 32'd19);
        check_vec({tag, "_busy_cnt"}, 32'(busy_cnt), 32'd18);
        check_vec({tag, "_clr_cnt"},  32'(clr_cnt),  32'd1);
        check_vec({tag, "_clr_cyc"},  32'(clr_cyc),  32'd1);
        check_vec({tag, "_nwr"},      32'(wq_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wq_addr.size()) begin
                check_vec({tag, "_addr"}, 32'(wq_addr[i]), 32'(i));
                check_vec({tag, "_z"},    32'(wq_data[i]), 32'(EXP_Z1[i]));
                check_vec({tag, "_wcyc"}, 32'(wq_cyc[i]),  32'(EXP_C1[i]));
            end
        end
        if (xa_q.size() >= 16) begin
            check_vec({tag, "_xa7"},  32'(xa_q[6]),  32'd1);
            check_vec({tag, "_ya7"},  32'(ya_q[6]),  32'd0);
            check_vec({tag, "_xa16"}, 32'(xa_q[15]), 32'd2);
            check_vec({tag, "_ya16"}, 32'(ya_q[15]), 32'd1);
        end else begin
            check_vec({tag, "_trace_len"}, 32'(xa_q.size()), 32'd19);
        end
    endtask

    initial begin
        int dc, bc, cc, cy, stray;
        n_vec  = 0;
        n_err  = 0;
        rsth   = 1'b1;
        start  = 1'b0;
        size_x = 6'd0;
        size_y = 6'd0;
        for (int i = 0; i < 32; i++) begin
            xmem[i] = 8'd0;
            ymem[i] = 8'd0;
        end
        repeat (3) @(negedge clk);
        check_zero("reset");
        rsth = 1'b0;

        // basic job
        xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3;
        ymem[0] = 8'd1; ymem[1] = 8'd1;
        run_job(3, 2, 0, dc, bc, cc, cy);
        check_basic("basic", dc, bc, cc, cy);

        // zero length
        run_job(0, 4, 0, dc, bc, cc, cy);
        check_vec("zero_done_cyc", 32'(dc), 32'd1);
        check_vec("zero_nwr",      32'(wq_addr.size()), 32'd0);
        check_vec("zero_busy",     32'(bc), 32'd0);
        check_vec("zero_clr",      32'(cc), 32'd0);

        // single element, addresses move back to 0 from the previous job
        xmem[0] = 8'd7; ymem[0] = 8'd9;
        run_job(1, 1, 0, dc, bc, cc, cy);
        check_vec("single_done_cyc", 32'(dc), 32'd5);
        check_vec("single_nwr",      32'(wq_addr.size()), 32'd1);
        if (wq_addr.size() > 0) begin
            check_vec("single_addr", 32'(wq_addr[0]), 32'd0);
            check_vec("single_z",    32'(wq_data[0]), 32'd63);
        end
        if (xa_q.size() > 1) begin
            check_vec("single_xa", 32'(xa_q[1]), 32'd0);
            check_vec("single_ya", 32'(ya_q[1]), 32'd0);
        end

        // overflow
        xmem[0] = 8'd255; xmem[1] = 8'd255;
        ymem[0] = 8'd255; ymem[1] = 8'd255;
        run_job(2, 2, 0, dc, bc, cc, cy);
        check_vec("ovf_done_cyc", 32'(dc), 32'd14);
        check_vec("ovf_nwr",      32'(wq_addr.size()), 32'd3);
        if (wq_data.size() == 3) begin
            check_vec("ovf_z0", 32'(wq_data[0]), 32'd65025);
`ifdef CONV_COPROC_SAT_EN
            check_vec("ovf_z1", 32'(wq_data[1]), 32'd65535);
`else
            check_vec("ovf_z1", 32'(wq_data[1]), 32'd64514);
`endif
            check_vec("ovf_z2", 32'(wq_data[2]), 32'd65025);
        end

        // ignored start and size change mid-job
        xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3;
        ymem[0] = 8'd1; ymem[1] = 8'd1;
        run_job(3, 2, 1, dc, bc, cc, cy);
        check_basic("restart", dc, bc, cc, cy);

        // reset mid-job, then no stray activity, then a clean rerun
        run_job(3, 2, 2, dc, bc, cc, cy);
        repeat (2) @(negedge clk);
        rsth  = 1'b0;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (res_en || busy || done) stray++;
        end
        check_vec("rst_no_stray", 32'(stray), 32'd0);
        run_job(3, 2, 0, dc, bc, cc, cy);
        check_basic("post_rst", dc, bc, cc, cy);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
